// File: rtl/cordic_mul_pkg.sv
// Shared definitions for the CORDIC pipelined multiplier: stage limit and helpers.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
// Contents: MAX_STAGE (upper bound on pipeline depth), clog2, sat_signed.
package cordic_mul_pkg;

  localparam int MAX_STAGE = 8;

  // Ceiling log2 for sizing indices; clog2(0) and clog2(1) both give 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Clamp a signed value into the two's complement range of 'width' bits.
  // For width = 64 the shifts wrap onto exactly the full 64-bit range,
  // so the clamp degenerates to a pass-through.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/cordic_mul_postproc.sv
// Product post-processing: optional round-half-up, arithmetic right shift, saturate or wrap.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; it has no handshake of its own.
// Ports: prod (signed full-precision product) -> result (DOUT_WIDTH bits).
module cordic_mul_postproc
  import cordic_mul_pkg::*;
#(
  parameter int PROD_WIDTH = 27,
  parameter int DOUT_WIDTH = 26,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0
) (
  input  logic signed [PROD_WIDTH-1:0] prod,
  output logic        [DOUT_WIDTH-1:0] result
);

  // One guard bit so that adding the rounding bias can never overflow.
  localparam int RW      = PROD_WIDTH + 1;
  localparam int BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND_BIAS =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << BIAS_SH) : RW'(0);

  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shf;
  logic signed [63:0]   s_ext;
  logic signed [63:0]   s_fin;

  always_comb begin
    rnd    = RW'(prod) + RND_BIAS;
    shf    = rnd >>> SHIFT;
    s_ext  = 64'(shf);
    s_fin  = (SAT != 0) ? sat_signed(s_ext, DOUT_WIDTH) : s_ext;
    // Without saturation this truncation is the required wrap.
    result = DOUT_WIDTH'(s_fin);
  end

endmodule

// File: rtl/cordic_mul_pipe.sv
// Pipelined multiplier with mixed signedness and shift/round/saturate post-processing.
// Latency: NUM_STAGE cycles from accept to out_valid; 1 beat/cycle throughput.
// Backpressure: valid/ready with bubble collapsing; in_ready drops only when every stage is full and out_ready=0.
// Ports: ap_clk, ap_rst_n (async active-low), in_valid/in_ready/din0/din1 (input beat),
//        out_valid/out_ready/dout (output beat), busy (any stage holds a valid beat).
module cordic_mul_pipe
  import cordic_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 12,
  parameter int DOUT_WIDTH  = 26,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SAT         = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

  if (NUM_STAGE < 0 || NUM_STAGE > MAX_STAGE) begin : g_bad_stage
    $fatal(1, "cordic_mul_pipe: NUM_STAGE=%0d outside 0..%0d", NUM_STAGE, MAX_STAGE);
  end
  if (SHIFT < 0 || SHIFT > DIN0_WIDTH + DIN1_WIDTH - 1) begin : g_bad_shift
    $fatal(1, "cordic_mul_pipe: SHIFT=%0d outside 0..%0d", SHIFT, DIN0_WIDTH + DIN1_WIDTH - 1);
  end
  if (DOUT_WIDTH < 2 || DOUT_WIDTH > 64) begin : g_bad_dout
    $fatal(1, "cordic_mul_pipe: DOUT_WIDTH=%0d outside 2..64", DOUT_WIDTH);
  end
  if (PW + 1 > 64) begin : g_bad_din
    $fatal(1, "cordic_mul_pipe: DIN0_WIDTH+DIN1_WIDTH too large");
  end

  // Unsigned operands get a 0 MSB so a single signed multiply covers every mix.
  logic signed [DIN0_WIDTH:0] op0;
  logic signed [DIN1_WIDTH:0] op1;
  logic signed [PW-1:0]       prod;
  logic [DOUT_WIDTH-1:0]      pp_dat;

  assign op0 = (DIN0_SIGNED != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
  assign op1 = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
  // |op0*op1| < 2^(DIN0_WIDTH+DIN1_WIDTH), so PW bits hold the exact product.
  assign prod = PW'(op0) * PW'(op1);

  cordic_mul_postproc #(
    .PROD_WIDTH (PW),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT)
  ) u_postproc (
    .prod   (prod),
    .result (pp_dat)
  );

  if (NUM_STAGE == 0) begin : g_comb
    // Clock and reset have no role without stages.
    logic unused_clk_rst;
    assign unused_clk_rst = ap_clk ^ ap_rst_n;

    assign dout      = pp_dat;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign busy      = 1'b0;
  end else begin : g_pipe
    logic [DOUT_WIDTH-1:0] dat_q [1:NUM_STAGE];
    logic [NUM_STAGE:1]    vld_q;
    logic [NUM_STAGE:1]    acc;

    // Unrolled form of acc[k] = ~v[k] | acc[k+1] with acc[N+1] = out_ready:
    // stage k may load if downstream is ready or any stage from k onward is empty.
    for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_acc
      assign acc[k] = out_ready | ~(&vld_q[NUM_STAGE:k]);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        vld_q <= '0;
        for (int k = 1; k <= NUM_STAGE; k++) dat_q[k] <= '0;
      end else begin
        if (acc[1]) begin
          vld_q[1] <= in_valid;
          dat_q[1] <= pp_dat;
        end
        for (int k = 2; k <= NUM_STAGE; k++) begin
          if (acc[k]) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end
    end

    assign in_ready  = acc[1];
    assign out_valid = vld_q[NUM_STAGE];
    assign dout      = dat_q[NUM_STAGE];
    assign busy      = |vld_q;
  end

endmodule

// File: tb/tb_cordic_mul_pipe.sv
// Directed self-checking bench for cordic_mul_pipe over several parameter sets sharing one input stream.
// Latency: checks exact NUM_STAGE-cycle latency and full throughput.
// Backpressure: exercises stalls, bubbles, full-pipe accept-while-emit and async reset mid-flight.
module tb_cordic_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        out_ready;

  wire [6:0]  ir;
  wire [6:0]  ov;
  wire [6:0]  bz;
  wire [25:0] do0;
  wire [15:0] do1;
  wire [15:0] do2;
  wire [25:0] do3;
  wire [25:0] do4;
  wire [25:0] do5;
  wire [25:0] do6;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (N=2)
  cordic_mul_pipe u0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(do0), .busy(bz[0]));

  // u1: 16-bit output, saturating
  cordic_mul_pipe #(.DOUT_WIDTH(16), .SAT(1)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(do1), .busy(bz[1]));

  // u2: 16-bit output, wrapping
  cordic_mul_pipe #(.DOUT_WIDTH(16), .SAT(0)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(do2), .busy(bz[2]));

  // u3: shift 4 with rounding, signed din1
  cordic_mul_pipe #(.SHIFT(4), .ROUND(1), .DIN1_SIGNED(1)) u3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(out_ready),
    .dout(do3), .busy(bz[3]));

  // u4: shift 4 without rounding, signed din1
  cordic_mul_pipe #(.SHIFT(4), .ROUND(0), .DIN1_SIGNED(1)) u4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
    .din0(din0), .din1(din1), .out_valid(ov[4]), .out_ready(out_ready),
    .dout(do4), .busy(bz[4]));

  // u5: three stages for the backpressure/bubble scenarios
  cordic_mul_pipe #(.NUM_STAGE(3)) u5 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[5]),
    .din0(din0), .din1(din1), .out_valid(ov[5]), .out_ready(out_ready),
    .dout(do5), .busy(bz[5]));

  // u6: combinational pass-through
  cordic_mul_pipe #(.NUM_STAGE(0)) u6 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[6]),
    .din0(din0), .din1(din1), .out_valid(ov[6]), .out_ready(out_ready),
    .dout(do6), .busy(bz[6]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then let combinational outputs settle.
  task automatic step(input logic iv, input logic [13:0] a, input logic [11:0] b, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    din0      = a;
    din1      = b;
    out_ready = ordy;
    #1;
  endtask

  // One cycle of the N=3 scenarios (din1 fixed at 10) with expected handshake/output.
  task automatic pstep(input string tag, input logic iv, input logic [13:0] a, input logic ordy,
                       input logic eir, input logic eov, input logic [25:0] edo);
    step(iv, a, 12'd10, ordy);
    chk({tag, "_in_ready"}, 32'(ir[5]), 32'(eir));
    chk({tag, "_out_valid"}, 32'(ov[5]), 32'(eov));
    if (eov) chk({tag, "_dout"}, 32'(do5), 32'(edo));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_dout", 32'(do0), 32'd0);
    chk("rst_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_busy_n3", 32'(bz[5]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: -3 * 4095 = -12285; N=0 instance shows it immediately.
    step(1'b1, 14'h3FFD, 12'hFFF, 1'b1);
    chk("lat_accept", 32'(ir[0]), 32'd1);
    chk("n0_out_valid", 32'(ov[6]), 32'd1);
    chk("n0_dout", 32'(do6), 32'h3FFD003);
    chk("n0_busy", 32'(bz[6]), 32'd0);
    chk("n0_in_ready", 32'(ir[6]), 32'd1);
    step(1'b0, 14'h0, 12'h0, 1'b1);
    chk("lat_c1_out_valid", 32'(ov[0]), 32'd0);
    chk("lat_c1_busy", 32'(bz[0]), 32'd1);
    chk("n0_idle_out_valid", 32'(ov[6]), 32'd0);
    step(1'b0, 14'h0, 12'h0, 1'b1);
    chk("lat_c2_out_valid", 32'(ov[0]), 32'd1);
    chk("lat_c2_dout", 32'(do0), 32'h3FFD003);
    step(1'b0, 14'h0, 12'h0, 1'b0);
    chk("n0_in_ready_follows", 32'(ir[6]), 32'd0);
    chk("lat_drained", 32'(ov[0]), 32'd0);

    // Back-to-back vectors: 8191*4095, -8192*4095, 6*4, -6*4.
    step(1'b1, 14'h1FFF, 12'hFFF, 1'b1);
    step(1'b1, 14'h2000, 12'hFFF, 1'b1);
    step(1'b1, 14'h0006, 12'h004, 1'b1);
    chk("sat_pos_valid", 32'(ov[1]), 32'd1);
    chk("sat_pos", 32'(do1), 32'h7FFF);
    chk("wrap_pos", 32'(do2), 32'hD001);
    step(1'b1, 14'h3FFA, 12'h004, 1'b1);
    chk("sat_neg", 32'(do1), 32'h8000);
    step(1'b0, 14'h0, 12'h0, 1'b1);
    chk("rnd_pos_valid", 32'(ov[3]), 32'd1);
    chk("rnd_pos", 32'(do3), 32'd2);
    chk("trunc_pos", 32'(do4), 32'd1);
    chk("plain_pos", 32'(do0), 32'd24);
    step(1'b0, 14'h0, 12'h0, 1'b1);
    chk("rnd_neg", 32'(do3), 32'h3FFFFFF);
    chk("trunc_neg", 32'(do4), 32'h3FFFFFE);
    chk("plain_neg", 32'(do0), 32'h3FFFFE8);
    step(1'b0, 14'h0, 12'h0, 1'b1);
    chk("stream_end", 32'(ov[3]), 32'd0);

    // Backpressure on the 3-stage instance: stall, hold, then accept-while-emit.
    pulse_reset();
    pstep("bp0",  1'b1, 14'd1, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bp1",  1'b1, 14'd2, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bp2",  1'b1, 14'd3, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bp3",  1'b1, 14'd4, 1'b0, 1'b0, 1'b1, 26'd10);
    pstep("bp4",  1'b1, 14'd4, 1'b0, 1'b0, 1'b1, 26'd10);
    pstep("bp5",  1'b1, 14'd4, 1'b0, 1'b0, 1'b1, 26'd10);
    pstep("bp6",  1'b1, 14'd4, 1'b1, 1'b1, 1'b1, 26'd10);
    pstep("bp7",  1'b1, 14'd5, 1'b1, 1'b1, 1'b1, 26'd20);
    pstep("bp8",  1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd30);
    pstep("bp9",  1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd40);
    pstep("bp10", 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd50);
    pstep("bp11", 1'b0, 14'd0, 1'b1, 1'b1, 1'b0, 26'd0);

    // Bubbles collapse under a stall: input stays open until three beats are held.
    pulse_reset();
    pstep("bub0", 1'b1, 14'd1, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bub1", 1'b0, 14'd0, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bub2", 1'b1, 14'd2, 1'b0, 1'b1, 1'b0, 26'd0);
    pstep("bub3", 1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 26'd10);
    pstep("bub4", 1'b1, 14'd3, 1'b0, 1'b1, 1'b1, 26'd10);
    pstep("bub5", 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 26'd10);
    pstep("bub6", 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd10);
    pstep("bub7", 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd20);
    pstep("bub8", 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 26'd30);
    pstep("bub9", 1'b0, 14'd0, 1'b1, 1'b1, 1'b0, 26'd0);

    // Asynchronous reset with two beats in flight in the 2-stage instance.
    step(1'b1, 14'h3FFD, 12'hFFF, 1'b1);
    step(1'b1, 14'd7, 12'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("inflight_out_valid", 32'(ov[0]), 32'd1);
    chk("inflight_busy", 32'(bz[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov[0]), 32'd0);
    chk("arst_busy", 32'(bz[0]), 32'd0);
    chk("arst_dout", 32'(do0), 32'd0);
    chk("arst_in_ready", 32'(ir[0]), 32'd1);
    chk("arst_busy_n3", 32'(bz[5]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 14'h0, 12'h0, 1'b1);
      chk($sformatf("post_rst_%0d_out_valid", i), 32'(ov[0]), 32'd0);
      chk($sformatf("post_rst_%0d_out_valid_n3", i), 32'(ov[5]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
